// File: rtl/cprv_id_stage.sv
// Decode stage: regfile read, immediate/field decode and shadow PC, registered
// toward execute behind a single-entry valid/ready pipeline register.
module cprv_id_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_id_i,
    output logic                   ready_id_o,
    input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
    input  logic                   flush_i,
    input  logic [DATA_WIDTH-1:0]  flush_pc_i,
    output logic [4:0]             rs1_addr_o,
    output logic [4:0]             rs2_addr_o,
    input  logic [DATA_WIDTH-1:0]  rs1_data_i,
    input  logic [DATA_WIDTH-1:0]  rs2_data_i,
    output logic                   valid_ex_o,
    input  logic                   ready_ex_i,
    output logic [DATA_WIDTH-1:0]  pc_ex_o,
    output logic [6:0]             opcode_ex_o,
    output logic [2:0]             funct3_ex_o,
    output logic [6:0]             funct7_ex_o,
    output logic [4:0]             rd_addr_ex_o,
    output logic                   rd_we_ex_o,
    output logic [DATA_WIDTH-1:0]  rs1_data_ex_o,
    output logic [DATA_WIDTH-1:0]  rs2_data_ex_o,
    output logic [DATA_WIDTH-1:0]  imm_ex_o,
    output logic                   illegal_ex_o
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic                  cke;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  we_d;
    logic                  illegal_d;

    assign cke        = ~valid_ex_o | ready_ex_i;
    assign ready_id_o = cke & ~rst;
    assign instr      = instr_data_id_i[31:0];
    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign rs1_addr_o = instr[19:15];
    assign rs2_addr_o = instr[24:20];

    // Opcode list already has [1:0]=2'b11, so the default arm covers compressed/bad low bits.
    always_comb begin
        imm_d     = '0;
        we_d      = 1'b0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
                imm_d = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
                we_d  = 1'b1;
            end
            OPC_SYSTEM, OPC_MISC_MEM:
                imm_d = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm_d = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm_d = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: begin
                imm_d = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
                we_d  = 1'b1;
            end
            OPC_JAL: begin
                imm_d = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
                we_d  = 1'b1;
            end
            OPC_OP, OPC_OP32:
                we_d = 1'b1;
            default:
                illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_ex_o    <= 1'b0;
            pc_ex_o       <= '0;
            opcode_ex_o   <= '0;
            funct3_ex_o   <= '0;
            funct7_ex_o   <= '0;
            rd_addr_ex_o  <= '0;
            rd_we_ex_o    <= 1'b0;
            rs1_data_ex_o <= '0;
            rs2_data_ex_o <= '0;
            imm_ex_o      <= '0;
            illegal_ex_o  <= 1'b0;
            pc_q          <= RESET_PC;
        end else if (flush_i) begin
            // Anything accepted this cycle is swallowed; data fields keep their old value.
            valid_ex_o <= 1'b0;
            pc_q       <= flush_pc_i;
        end else if (cke) begin
            valid_ex_o    <= valid_id_i;
            pc_ex_o       <= pc_q;
            opcode_ex_o   <= opcode;
            funct3_ex_o   <= instr[14:12];
            funct7_ex_o   <= instr[31:25];
            rd_addr_ex_o  <= rd;
            rd_we_ex_o    <= we_d & (rd != 5'd0);
            rs1_data_ex_o <= (rs1_addr_o == 5'd0) ? '0 : rs1_data_i;
            rs2_data_ex_o <= (rs2_addr_o == 5'd0) ? '0 : rs2_data_i;
            imm_ex_o      <= imm_d;
            illegal_ex_o  <= illegal_d;
            if (valid_id_i)
                pc_q <= pc_q + DATA_WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_cprv_id_stage.sv
// Bench for cprv_id_stage: directed plan items with literal expectations, then
// random traffic compared each cycle against an arithmetic reference model.
module tb_cprv_id_stage;

    logic        clk;
    logic        rst;
    logic        valid_id;
    logic        ready_id_o;
    logic [31:0] instr;
    logic        flush;
    logic [63:0] flush_pc;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [63:0] rs1d, rs2d;
    logic        valid_ex_o;
    logic        ready_ex;
    logic [63:0] pc_ex_o;
    logic [6:0]  opcode_ex_o;
    logic [2:0]  funct3_ex_o;
    logic [6:0]  funct7_ex_o;
    logic [4:0]  rd_addr_ex_o;
    logic        rd_we_ex_o;
    logic [63:0] rs1_data_ex_o, rs2_data_ex_o, imm_ex_o;
    logic        illegal_ex_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit en     = 0;

    cprv_id_stage dut (
        .clk(clk), .rst(rst),
        .valid_id_i(valid_id), .ready_id_o(ready_id_o),
        .instr_data_id_i(instr),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1d), .rs2_data_i(rs2d),
        .valid_ex_o(valid_ex_o), .ready_ex_i(ready_ex),
        .pc_ex_o(pc_ex_o), .opcode_ex_o(opcode_ex_o),
        .funct3_ex_o(funct3_ex_o), .funct7_ex_o(funct7_ex_o),
        .rd_addr_ex_o(rd_addr_ex_o), .rd_we_ex_o(rd_we_ex_o),
        .rs1_data_ex_o(rs1_data_ex_o), .rs2_data_ex_o(rs2_data_ex_o),
        .imm_ex_o(imm_ex_o), .illegal_ex_o(illegal_ex_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] imm;
        logic        ill;
    } bnd_t;

    // Immediates built by weighting bit fields arithmetically, sign bit subtracted.
    function automatic bnd_t model_decode(input logic [31:0] in, input logic [63:0] d1,
                                          input logic [63:0] d2, input logic [63:0] pc);
        bnd_t   b;
        longint v;
        longint s;
        logic [6:0] op;
        op   = in[6:0];
        s    = in[31] ? 64'sd1 : 64'sd0;
        b.pc = pc;
        b.op = op;
        b.f3 = in[14:12];
        b.f7 = in[31:25];
        b.rd = in[11:7];
        b.r1 = (in[19:15] == 0) ? 64'd0 : d1;
        b.r2 = (in[24:20] == 0) ? 64'd0 : d2;
        b.we = 0;
        b.ill = 0;
        v = 0;
        case (op)
            7'h67, 7'h03, 7'h13, 7'h1B: begin
                v = longint'(in[30:20]) - s * 2048; b.we = 1;
            end
            7'h73, 7'h0F: v = longint'(in[30:20]) - s * 2048;
            7'h23: v = longint'(in[11:7]) + longint'(in[30:25]) * 32 - s * 2048;
            7'h63: v = longint'(in[11:8]) * 2 + longint'(in[30:25]) * 32
                       + longint'(in[7]) * 2048 - s * 4096;
            7'h37, 7'h17: begin
                v = longint'(in[30:12]) * 4096 - s * 64'sh8000_0000; b.we = 1;
            end
            7'h6F: begin
                v = longint'(in[30:21]) * 2 + longint'(in[20]) * 2048
                    + longint'(in[19:12]) * 4096 - s * 64'sh10_0000;
                b.we = 1;
            end
            7'h33, 7'h3B: begin v = 0; b.we = 1; end
            default: b.ill = 1;
        endcase
        if (b.rd == 0) b.we = 0;
        b.imm = v;
        return b;
    endfunction

    bit          m_valid = 0;
    bit          m_known = 0;
    bnd_t        m_bnd   = '0;
    logic [63:0] m_pc    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_known = 1; m_bnd = '0; m_pc = 0;
        end else if (flush) begin
            m_valid = 0; m_known = 0; m_pc = flush_pc;
        end else if (!m_valid || ready_ex) begin
            m_valid = valid_id;
            m_known = valid_id;
            if (valid_id) begin
                m_bnd = model_decode(instr, rs1d, rs2d, m_pc);
                m_pc  = m_pc + 64'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("ready_id", 64'(ready_id_o), 64'((!m_valid || ready_ex) && !rst));
            chk("rs1_addr", 64'(rs1_addr_o), 64'(instr[19:15]));
            chk("rs2_addr", 64'(rs2_addr_o), 64'(instr[24:20]));
            chk("valid_ex", 64'(valid_ex_o), 64'(m_valid));
            if (m_known) begin
                chk("pc_ex",    pc_ex_o,              m_bnd.pc);
                chk("opcode",   64'(opcode_ex_o),     64'(m_bnd.op));
                chk("funct3",   64'(funct3_ex_o),     64'(m_bnd.f3));
                chk("funct7",   64'(funct7_ex_o),     64'(m_bnd.f7));
                chk("rd_addr",  64'(rd_addr_ex_o),    64'(m_bnd.rd));
                chk("rd_we",    64'(rd_we_ex_o),      64'(m_bnd.we));
                chk("rs1_data", rs1_data_ex_o,        m_bnd.r1);
                chk("rs2_data", rs2_data_ex_o,        m_bnd.r2);
                chk("imm",      imm_ex_o,             m_bnd.imm);
                chk("illegal",  64'(illegal_ex_o),    64'(m_bnd.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; valid_id = 0; flush = 0;
        step(); step();
        rst = 0;
    endtask

    logic [6:0] opc_pool [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23,
                                  7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F};

    initial begin
        rst = 1; valid_id = 0; flush = 0; ready_ex = 0; instr = 0;
        flush_pc = 0; rs1d = 0; rs2d = 0;
        step(); en = 1; step();
        chk("rst_valid", 64'(valid_ex_o), 64'd0);
        chk("rst_ready", 64'(ready_id_o), 64'd0);
        chk("rst_pc", pc_ex_o, 64'd0);
        chk("rst_imm", imm_ex_o, 64'd0);
        rst = 0; ready_ex = 1; #1;
        chk("ready_after_rst", 64'(ready_id_o), 64'd1);

        // addi x1,x0,5
        valid_id = 1; instr = 32'h0050_0093; rs1d = 64'hDEAD; rs2d = 64'h1;
        step();
        chk("addi_valid", 64'(valid_ex_o), 64'd1);
        chk("addi_pc", pc_ex_o, 64'd0);
        chk("addi_opc", 64'(opcode_ex_o), 64'h13);
        chk("addi_rd", 64'(rd_addr_ex_o), 64'd1);
        chk("addi_we", 64'(rd_we_ex_o), 64'd1);
        chk("addi_imm", imm_ex_o, 64'd5);
        chk("addi_rs1", rs1_data_ex_o, 64'd0);

        // lui then beq back-to-back
        do_reset();
        ready_ex = 1; valid_id = 1; instr = 32'h8000_0137;
        step();
        chk("lui_imm", imm_ex_o, 64'hFFFF_FFFF_8000_0000);
        chk("lui_pc", pc_ex_o, 64'd0);
        instr = 32'hFE00_0EE3;
        step();
        chk("beq_valid", 64'(valid_ex_o), 64'd1);
        chk("beq_imm", imm_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_pc", pc_ex_o, 64'd4);
        chk("beq_we", 64'(rd_we_ex_o), 64'd0);

        // sw x2,8(x1) held for 3 stalled cycles
        instr = 32'h0020_A423; rs1d = 64'h1000; rs2d = 64'h55;
        step();
        ready_ex = 0; instr = 32'h0050_0093; rs1d = 64'h77; rs2d = 64'h88;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw_imm", imm_ex_o, 64'd8);
            chk("sw_we", 64'(rd_we_ex_o), 64'd0);
            chk("sw_rs1", rs1_data_ex_o, 64'h1000);
            chk("sw_rs2", rs2_data_ex_o, 64'h55);
            chk("sw_pc", pc_ex_o, 64'd8);
            chk("sw_ready", 64'(ready_id_o), 64'd0);
        end
        ready_ex = 1; #1;
        chk("release_ready", 64'(ready_id_o), 64'd1);
        step();
        chk("after_sw_pc", pc_ex_o, 64'd12);
        chk("after_sw_opc", 64'(opcode_ex_o), 64'h13);

        // flush while holding a bundle
        ready_ex = 0; instr = 32'h8000_0137;
        step();
        flush = 1; flush_pc = 64'h80;
        step();
        chk("flush_valid", 64'(valid_ex_o), 64'd0);
        flush = 0; ready_ex = 1; instr = 32'h0050_0093;
        step();
        chk("flush_pc", pc_ex_o, 64'h80);
        chk("flush_next_valid", 64'(valid_ex_o), 64'd1);

        // shadow PC wrap
        flush = 1; flush_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        flush = 0;
        step();
        chk("wrap_pc0", pc_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc1", pc_ex_o, 64'd0);

        // illegal encodings
        instr = 32'h0000_0000;
        step();
        chk("ill0_flag", 64'(illegal_ex_o), 64'd1);
        chk("ill0_we", 64'(rd_we_ex_o), 64'd0);
        chk("ill0_imm", imm_ex_o, 64'd0);
        chk("ill0_valid", 64'(valid_ex_o), 64'd1);
        instr = 32'h0000_007F;
        step();
        chk("ill7f_flag", 64'(illegal_ex_o), 64'd1);
        chk("ill7f_imm", imm_ex_o, 64'd0);
        chk("ill7f_valid", 64'(valid_ex_o), 64'd1);

        // reset mid-stream with a stalled bundle
        ready_ex = 0;
        step();
        chk("pre_rst_valid", 64'(valid_ex_o), 64'd1);
        rst = 1; #1;
        chk("mid_rst_ready", 64'(ready_id_o), 64'd0);
        step();
        chk("mid_rst_valid", 64'(valid_ex_o), 64'd0);
        rst = 0; ready_ex = 1; valid_id = 1; instr = 32'h0050_0093;
        step();
        chk("post_rst_pc", pc_ex_o, 64'd0);
        chk("post_rst_valid", 64'(valid_ex_o), 64'd1);

        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 99) < 2);
            flush    = ($urandom_range(0, 99) < 5);
            flush_pc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                   : {$urandom, $urandom};
            valid_id = ($urandom_range(0, 99) < 75);
            ready_ex = ($urandom_range(0, 99) < 70);
            instr    = $urandom;
            if ($urandom_range(0, 99) < 85)
                instr[6:0] = opc_pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) instr[19:15] = 5'd0;
            if ($urandom_range(0, 9) == 0) instr[24:20] = 5'd0;
            if ($urandom_range(0, 9) == 0) instr[11:7] = 5'd0;
            rs1d = {$urandom, $urandom};
            rs2d = {$urandom, $urandom};
            step();
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cprv_id_stage.md
Name: cprv_id_stage

Overview:
Instruction decode stage of the cprv64g pipeline. It sits directly downstream of the fetch stage and consumes its valid/ready instruction stream. For each instruction it reads the register file, generates the immediate and decode fields, and tracks a shadow PC. It registers the result toward the execute stage behind a valid/ready handshake with one entry of buffering.

Parameters:
INSTR_WIDTH, 32, instruction width in bits
DATA_WIDTH, 64, XLEN; width of PC, operands and immediate
RESET_PC, 0, shadow PC value after reset; matches the fetch stage start address

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_id_i  input  1  instruction valid from fetch stage
ready_id_o  output  1  decode can accept an instruction this cycle
instr_data_id_i  input  INSTR_WIDTH  instruction from fetch stage
flush_i  input  1  discard held and incoming instructions; reload shadow PC
flush_pc_i  input  DATA_WIDTH  new shadow PC value when flush_i=1
rs1_addr_o  output  5  regfile read address 1 = instr_data_id_i[19:15] (combinational)
rs2_addr_o  output  5  regfile read address 2 = instr_data_id_i[24:20] (combinational)
rs1_data_i  input  DATA_WIDTH  regfile read data 1, same cycle
rs2_data_i  input  DATA_WIDTH  regfile read data 2, same cycle
valid_ex_o  output  1  decoded bundle valid to execute stage
ready_ex_i  input  1  execute stage accepts the bundle
pc_ex_o  output  DATA_WIDTH  PC of the instruction
opcode_ex_o  output  7  instr[6:0]
funct3_ex_o  output  3  instr[14:12]
funct7_ex_o  output  7  instr[31:25]
rd_addr_ex_o  output  5  instr[11:7]
rd_we_ex_o  output  1  instruction writes rd, and rd!=0
rs1_data_ex_o  output  DATA_WIDTH  operand 1; forced 0 when rs1=x0
rs2_data_ex_o  output  DATA_WIDTH  operand 2; forced 0 when rs2=x0
imm_ex_o  output  DATA_WIDTH  sign-extended immediate
illegal_ex_o  output  1  unsupported or illegal encoding

Behaviour:
- Handshake:
  - cke = ~valid_ex_o | ready_ex_i.
  - ready_id_o = cke & ~rst.
  - Accept = valid_id_i & ready_id_o.
- Pipeline register. On a cycle with cke=1 and no rst/flush, all *_ex_o fields load from the current decode and valid_ex_o <= valid_id_i. Latency from acceptance to valid_ex_o is 1 cycle.
- Hold. When cke=0, all *_ex_o outputs hold stable. Data fields may change only when cke=1.
- Reset (priority 1):
  - valid_ex_o=0; all data outputs 0.
  - Shadow PC = RESET_PC.
  - ready_id_o=0 during reset, and 1 in the first cycle after reset.
- Flush (priority 2, when rst=0):
  - valid_ex_o <= 0 next cycle, whatever ready_ex_i is.
  - ready_id_o still follows cke. An instruction accepted in the flush cycle is consumed and discarded.
  - Shadow PC <= flush_pc_i. The next accepted instruction carries pc_ex_o=flush_pc_i.
- Shadow PC:
  - Each accepted, non-flushed instruction is tagged with the current shadow PC.
  - The shadow PC then increments by 4, modulo 2^DATA_WIDTH; wrap from all-ones-minus-3 to 0 is silent.
- Immediate generation (sign bit is instr[31], extended to DATA_WIDTH):
  - I-type: JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, SYSTEM 1110011, MISC-MEM 0001111.
  - S-type: STORE 0100011.
  - B-type: BRANCH 1100011; bit0=0.
  - U-type: LUI 0110111, AUIPC 0010111; instr[31:12]<<12, sign-extended.
  - J-type: JAL 1101111; bit0=0.
  - OP 0110011 and OP-32 0111011: imm=0.
- rd_we_ex_o = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP-IMM-32, OP, OP-32, and only when rd!=0. Otherwise 0.
- illegal_ex_o = 1 when instr[1:0]!=2'b11 or the opcode is not in the list above. In that case rd_we_ex_o=0 and imm_ex_o=0; the bundle is still passed on with valid=1.
- Register data is captured on the same edge as the other fields. Zero-forcing for x0 is applied at capture, independent of rs*_data_i.
- Simultaneous events:
  - ready_ex_i=1 together with a new accept: the old bundle leaves and the new one loads in the same cycle (full throughput, 1 instruction/cycle).
  - valid_id_i=0 with cke=1: valid_ex_o drops to 0 and data may update.

Test Plan:
- Reset, then feed 0x00500093 (addi x1,x0,5) with rs1_data_i=0xDEAD → next cycle: valid_ex_o=1, pc=0, opcode=0x13, rd=1, rd_we=1, imm=5, rs1_data_ex=0.
- Back-to-back 0x80000137 (lui x2,0x80000), then 0xFE000EE3 (beq x0,x0,-4), with ready_ex_i=1 → imm 0xFFFFFFFF80000000 at pc=0, then 0xFFFFFFFFFFFFFFFC at pc=4 with rd_we=0, on consecutive cycles.
- 0x0020A423 (sw x2,8(x1)) with rs1=0x1000, rs2=0x55, and ready_ex_i=0 for 3 cycles → imm=8, rd_we=0; bundle stable for all 3 cycles; ready_id_o=0 while stalled; released on the first ready_ex_i=1.
- Flush with flush_pc_i=0x80 while a bundle is held and valid_id_i=1 → valid_ex_o=0 next cycle; incoming instruction dropped; next accepted instruction has pc_ex_o=0x80.
- Illegal encodings 0x00000000 and 0x0000007F → illegal_ex_o=1, rd_we_ex_o=0, imm_ex_o=0, valid_ex_o=1.
- Assert rst mid-stream with valid_ex_o=1 and ready_ex_i=0 → valid_ex_o=0 and ready_id_o=0 during reset; the first instruction after reset gets pc=RESET_PC.
